testpat_multi: RTL and testbench

TESTPAT_MULTI -- requirements
Module: testpat_multi

---
 rtl/testpat_multi.sv | 149 ++++++++++++++
 tb/tb_testpat_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/testpat_multi.sv
// Multi-channel test-pattern generator: START/STOP run control, elapsed-cycle counter,
// and toggle / LFSR / walking-one pattern sources gated by a per-channel enable mask.
module testpat_multi #(
    parameter int          CH      = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned MAX_CYC = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE,
    input  logic [CH-1:0]    CH_EN,
    output logic [CH-1:0]    PAT,
    output logic             RO,
    output logic             OW,
    output logic             DONE,
    output logic [CNT_W-1:0] Laikas
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYC);

    // Bit 0 carries START, bit 1 carries STOP through the same synchroniser path.
    logic [1:0]       w_req;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_prev;
    logic [1:0]       r_arm;
    logic [1:0]       r_vld;
    logic [1:0]       w_evt;

    state_t           r_state;
    logic [CNT_W-1:0] r_laikas;
    logic             r_ow;
    logic             r_done;
    logic             r_auto;
    logic [1:0]       r_mode;
    logic [15:0]      r_lfsr;
    logic [CH-1:0]    r_walk;
    logic [CH-1:0]    r_tog;
    logic [CH-1:0]    w_tog_init;
    logic [CH-1:0]    w_pat_raw;
    logic [15:0]      w_lfsr_next;
    logic             w_run;
    logic             w_leave;
    logic             w_enter;
    logic             w_lk_max;
    logic             w_at_limit;

    assign w_req = {STOP, START};

    // An edge only counts once the synchronised input has been seen low after reset,
    // so a request held high through reset cannot fire on release.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_arm   <= '0;
            r_vld   <= '0;
        end else begin
            r_sync1 <= w_req;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_vld   <= {r_vld[0], 1'b1};
            r_arm   <= r_arm | ({2{r_vld[1]}} & ~r_sync2);
        end
    end

    assign w_evt = r_sync2 & ~r_prev & r_arm;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_tog_init
            assign w_tog_init[gi] = ((gi % 2) == 1);
        end
    endgenerate

    assign w_run       = (r_state == S_RUN);
    assign w_lk_max    = &r_laikas;
    assign w_at_limit  = (MAX_CYC != 0) && (r_laikas == MAX_V);
    assign w_leave     = w_run && (w_evt[1] || r_auto);
    assign w_enter     = w_evt[0] && !w_leave;
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_IDLE;
            r_laikas <= '0;
            r_ow     <= 1'b0;
            r_done   <= 1'b0;
            r_auto   <= 1'b0;
            r_mode   <= 2'd0;
            r_lfsr   <= SEED;
            r_walk   <= '0;
            r_tog    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_leave) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_auto  <= 1'b0;
            end else if (w_enter) begin
                r_state  <= S_RUN;
                r_laikas <= '0;
                r_ow     <= 1'b0;
                r_auto   <= 1'b0;
                r_mode   <= MODE;
                r_lfsr   <= SEED;
                r_walk   <= CH'(1);
                r_tog    <= w_tog_init;
            end else if (w_run) begin
                // Hitting the auto-stop count holds the counter and stops one edge later.
                if (w_lk_max) begin
                    r_ow <= 1'b1;
                end else if (!w_at_limit) begin
                    r_laikas <= r_laikas + 1'b1;
                end
                if (w_at_limit) begin
                    r_auto <= 1'b1;
                end
                r_lfsr <= w_lfsr_next;
                r_walk <= (r_walk << 1) | (r_walk >> (CH - 1));
                r_tog  <= ~r_tog;
            end
        end
    end

    always_comb begin
        w_pat_raw = '0;
        if (w_run) begin
            case (r_mode)
                2'd1:    w_pat_raw = r_tog;
                2'd2:    w_pat_raw = r_lfsr[CH-1:0];
                2'd3:    w_pat_raw = r_walk;
                default: w_pat_raw = '0;
            endcase
        end
    end

    assign PAT    = w_pat_raw & CH_EN;
    assign RO     = w_run;
    assign OW     = r_ow;
    assign DONE   = r_done;
    assign Laikas = r_laikas;

endmodule

// File: tb/tb_testpat_multi.sv
// Scoreboard bench for testpat_multi: three instances (default, 4-bit counter, 16 channels
// with auto-stop at 10) driven by directed vectors; monitors pop expected PAT / Laikas values.
module tb_testpat_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: CH=4, CNT_W=32, no auto-stop
    logic        a_rst_n, a_start, a_stop, a_ro, a_ow, a_done;
    logic [1:0]  a_mode;
    logic [3:0]  a_en, a_pat;
    logic [31:0] a_lk;
    // Instance B: CH=4, CNT_W=4
    logic        b_rst_n, b_start, b_stop, b_ro, b_ow, b_done;
    logic [1:0]  b_mode;
    logic [3:0]  b_en, b_pat;
    logic [3:0]  b_lk;
    // Instance C: CH=16, MAX_CYC=10
    logic        c_rst_n, c_start, c_stop, c_ro, c_ow, c_done;
    logic [1:0]  c_mode;
    logic [15:0] c_en, c_pat;
    logic [31:0] c_lk;

    testpat_multi #(.CH(4), .CNT_W(32), .MAX_CYC(0)) dut_a (
        .CLOCK_50(clk), .RESET_N(a_rst_n), .START(a_start), .STOP(a_stop),
        .MODE(a_mode), .CH_EN(a_en), .PAT(a_pat), .RO(a_ro), .OW(a_ow),
        .DONE(a_done), .Laikas(a_lk)
    );

    testpat_multi #(.CH(4), .CNT_W(4), .MAX_CYC(0)) dut_b (
        .CLOCK_50(clk), .RESET_N(b_rst_n), .START(b_start), .STOP(b_stop),
        .MODE(b_mode), .CH_EN(b_en), .PAT(b_pat), .RO(b_ro), .OW(b_ow),
        .DONE(b_done), .Laikas(b_lk)
    );

    testpat_multi #(.CH(16), .CNT_W(32), .MAX_CYC(10)) dut_c (
        .CLOCK_50(clk), .RESET_N(c_rst_n), .START(c_start), .STOP(c_stop),
        .MODE(c_mode), .CH_EN(c_en), .PAT(c_pat), .RO(c_ro), .OW(c_ow),
        .DONE(c_done), .Laikas(c_lk)
    );

    logic [31:0] q_pat_a[$];
    logic [31:0] q_done_a[$];
    logic [31:0] q_pat_c[$];
    logic [31:0] q_done_c[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors: compare PAT while running and Laikas at every DONE pulse.
    always @(negedge clk) begin
        if (a_ro && q_pat_a.size() != 0) check("a_pat", 32'(a_pat), q_pat_a.pop_front());
        if (a_done) begin
            if (q_done_a.size() == 0) check("a_done_spurious", 32'(a_done), 32'd0);
            else check("a_done_laikas", a_lk, q_done_a.pop_front());
        end
        if (b_done) check("b_done_spurious", 32'(b_done), 32'd0);
        if (c_ro && q_pat_c.size() != 0) check("c_pat", 32'(c_pat), q_pat_c.pop_front());
        if (c_done) begin
            if (q_done_c.size() == 0) check("c_done_spurious", 32'(c_done), 32'd0);
            else check("c_done_laikas", c_lk, q_done_c.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic ro_of(input int d);
        case (d)
            0:       return a_ro;
            1:       return b_ro;
            default: return c_ro;
        endcase
    endfunction

    task automatic wait_ro(input int d, input logic lvl, input int budget, input string name);
        int n = 0;
        while (ro_of(d) !== lvl && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(ro_of(d)), 32'(lvl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        a_rst_n = 0; a_start = 1; a_stop = 0; a_mode = 0; a_en = 4'hF;
        b_rst_n = 0; b_start = 0; b_stop = 0; b_mode = 0; b_en = 4'hF;
        c_rst_n = 0; c_start = 0; c_stop = 0; c_mode = 0; c_en = 16'hFFFF;
        tick(3);
        check("a_rst_outs", 32'({a_pat, a_ro, a_ow, a_done}), 32'd0);
        check("a_rst_laikas", a_lk, 32'd0);
        a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
        tick(6);
        check("a_held_start_no_run", 32'(a_ro), 32'd0);

        // Walking-one with a masked channel, then a 100-cycle run stopped by STOP
        a_mode = 2'd3; a_en = 4'b1011;
        q_pat_a.push_back(32'h1); q_pat_a.push_back(32'h2); q_pat_a.push_back(32'h0);
        q_pat_a.push_back(32'h8); q_pat_a.push_back(32'h1);
        a_start = 0; tick(2);
        a_start = 1; tick(1); a_start = 0;
        wait_ro(0, 1'b1, 10, "a_ro_walk");
        tick(100);
        q_done_a.push_back(32'd102);
        a_stop = 1; tick(1); a_stop = 0;
        tick(4);
        check("a_ro_after_stop", 32'(a_ro), 32'd0);
        check("a_laikas_hold", a_lk, 32'd102);
        check("a_pat_idle", 32'(a_pat), 32'd0);

        // Toggle mode; a MODE change mid-run must not affect the pattern
        a_mode = 2'd1; a_en = 4'hF;
        q_pat_a.push_back(32'hA); q_pat_a.push_back(32'h5); q_pat_a.push_back(32'hA);
        a_start = 1; tick(1); a_start = 0;
        wait_ro(0, 1'b1, 10, "a_ro_toggle");
        a_mode = 2'd2;
        tick(3);
        a_en = 4'b0011; #1;
        check("a_chen_immediate", 32'(a_pat), 32'h1);
        a_en = 4'hF;

        // START+STOP together in RUN: stop wins
        q_done_a.push_back(32'd5);
        a_start = 1; a_stop = 1; tick(1); a_start = 0; a_stop = 0;
        wait_ro(0, 1'b0, 10, "a_ro_simul_stop");

        // START+STOP together in IDLE: start wins; MODE=2 latched -> LFSR
        q_pat_a.push_back(32'h1); q_pat_a.push_back(32'h3);
        q_pat_a.push_back(32'h7); q_pat_a.push_back(32'hF);
        a_start = 1; a_stop = 1; tick(1); a_start = 0; a_stop = 0;
        wait_ro(0, 1'b1, 10, "a_ro_simul_start");
        check("a_laikas_entry", a_lk, 32'd0);
        tick(4);
        a_start = 1; tick(1); a_start = 0;
        tick(2);
        check("a_laikas_restart", a_lk, 32'd0);
        check("a_ro_restart", 32'(a_ro), 32'd1);
        check("a_pat_restart", 32'(a_pat), 32'h1);
        q_done_a.push_back(32'd2);
        a_stop = 1; tick(1); a_stop = 0;
        wait_ro(0, 1'b0, 10, "a_ro_stop2");

        // 4-bit counter saturation and OW clear on restart
        b_start = 1; tick(1); b_start = 0;
        wait_ro(1, 1'b1, 10, "b_ro");
        tick(10);
        check("b_laikas_10", 32'(b_lk), 32'd10);
        check("b_ow_clear", 32'(b_ow), 32'd0);
        tick(10);
        check("b_laikas_sat", 32'(b_lk), 32'd15);
        check("b_ow_set", 32'(b_ow), 32'd1);
        check("b_pat_mode0", 32'(b_pat), 32'd0);
        b_start = 1; tick(1); b_start = 0;
        tick(2);
        check("b_ow_restart", 32'(b_ow), 32'd0);
        check("b_laikas_restart", 32'(b_lk), 32'd0);
        check("b_ro_restart", 32'(b_ro), 32'd1);

        // 16-channel LFSR with auto-stop at 10
        c_mode = 2'd2; c_en = 16'hFFFF;
        q_pat_c.push_back(32'hACE1); q_pat_c.push_back(32'h59C3);
        q_pat_c.push_back(32'hB387); q_pat_c.push_back(32'h670F);
        q_done_c.push_back(32'd10);
        c_start = 1; tick(1); c_start = 0;
        wait_ro(2, 1'b1, 10, "c_ro");
        n = 0;
        while (c_ro && n < 50) begin
            n++;
            tick(1);
        end
        check("c_ro_cycles", 32'(n), 32'd12);
        check("c_laikas_hold", c_lk, 32'd10);

        // Reset mid-run aborts without DONE
        c_start = 1; tick(1); c_start = 0;
        wait_ro(2, 1'b1, 10, "c_ro2");
        tick(3);
        c_rst_n = 0; #1;
        check("c_rst_abort_outs", 32'({c_pat, c_ro, c_ow, c_done}), 32'd0);
        check("c_rst_abort_laikas", c_lk, 32'd0);
        tick(2);
        c_rst_n = 1;
        tick(5);
        check("c_ro_after_rst", 32'(c_ro), 32'd0);

        tick(3);
        check("queues_empty", 32'(q_pat_a.size() + q_done_a.size() + q_pat_c.size() + q_done_c.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
